iter_ctrl: RTL and testbench
============================

ITER_CTRL -- requirements
Module: iter_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: watchdog limit in RUN cycles; used only when ITER_CTRL_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin one 14-iteration pass; sampled only while ready=1.
REQ-005 ack  input  1  consumer acknowledge of done.
REQ-006 cnt_cout  input  1  carry from downstream mod-14 iteration counter; high when count=13.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 load_en  output  1  one-cycle strobe to load operand registers.
REQ-009 cnt_en  output  1  count enable to mod-14 counter.
REQ-010 acc_en  output  1  datapath accumulate enable, one per iteration.
REQ-011 done  output  1  pass complete; held until ack.
REQ-012 err  output  1  sticky timeout flag; constant 0 when the watchdog is compiled out.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, RUN, DONE, all outputs registered or state-decoded with no combinational path from inputs to outputs.
REQ-014 IDLE: ready=1, other outputs 0; start=1 -> LOAD next cycle.
REQ-015 LOAD: load_en=1 for exactly one cycle -> RUN unconditionally.
REQ-016 RUN: cnt_en=1 and acc_en=1 every cycle, including the cycle cnt_cout=1.
REQ-017 RUN with cnt_cout=1 -> DONE; the counter therefore wraps 13->0 on the same edge and starts the next pass at 0.
REQ-018 From counter value 0, RUN SHALL last exactly 14 cycles; start-to-done latency = 16 cycles (LOAD + 14 RUN + 1).
REQ-019 DONE: done=1, cnt_en=0, acc_en=0; ack=1 -> IDLE; ack absent -> stay in DONE indefinitely.
REQ-020 start outside IDLE SHALL be ignored, not queued; ack outside DONE ignored.
REQ-021 start and ack both high in DONE: ack honoured, start ignored; new pass needs start in IDLE.
REQ-022 cnt_cout outside RUN SHALL have no effect.

Reset
REQ-023 rst=0 SHALL force IDLE immediately, asynchronously, from any state including mid-RUN.
REQ-024 Reset values: ready=1, load_en=0, cnt_en=0, acc_en=0, done=0, err=0, watchdog count=0.
REQ-025 The counter shares rst; after reset both blocks start aligned at count 0.

Configuration
REQ-026 Macro ITER_CTRL_TIMEOUT_EN defined: a watchdog counts RUN cycles, cleared on entering RUN.
REQ-027 The watchdog width SHALL be $clog2(TIMEOUT+1).
REQ-028 If the count reaches TIMEOUT without cnt_cout, FSM -> DONE, err=1, and err stays set until reset.
REQ-029 Macro undefined: no watchdog logic, err tied 0, and RUN waits on cnt_cout forever.

Structure
REQ-030 Shared package iter_pkg SHALL hold the state enum typedef, ITER_COUNT=14, and the default TIMEOUT constant.
REQ-031 The watchdog SHALL be a sub-module iter_watchdog (clk, rst, clr, en, expired), instantiated only under ITER_CTRL_TIMEOUT_EN.
REQ-032 The mod-14 counter stays external; this block only drives cnt_en and reads cnt_cout.

Verification
REQ-033 Reset, start pulse at cycle 2 with a mod-14 counter model attached -> the bench SHALL check each item below:
- load_en high at cycle 3;
- cnt_en and acc_en high for 14 cycles;
- done high at cycle 18;
- counter reads 0 afterwards.
REQ-034 done held and ack withheld for 10 cycles -> done stays 1 and cnt_en stays 0; ack -> ready=1 the next cycle.
REQ-035 start pulses during LOAD, RUN and DONE -> no extra pass, and acc_en count stays exactly 14.
REQ-036 rst=0 asserted during RUN iteration 7 -> outputs reach reset values immediately; the next start gives a clean 14-iteration pass.
REQ-037 ITER_CTRL_TIMEOUT_EN defined, TIMEOUT=16, cnt_cout forced 0 -> DONE after 16 RUN cycles, err=1, and err held through ack until reset.
REQ-038 Back-to-back passes with ack and start in consecutive cycles -> two passes of exactly 14 acc_en cycles each.

Source files
------------

// File: rtl/iter_pkg.sv
// Shared definitions for the iteration controller: FSM state encoding,
// iteration count of the external counter, and the default watchdog limit.
package iter_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Iterations per pass (modulus of the external counter)
  localparam int unsigned ITER_COUNT = 32'd14;

  // Default watchdog limit in RUN cycles
  localparam int unsigned TIMEOUT_DEFAULT = 32'd16;

  // Width of a counter that must be able to hold the value t
  function automatic int unsigned wd_width(input int unsigned t);
    return $clog2(t + 32'd1);
  endfunction

endpackage

// File: rtl/iter_ctrl_if.sv
// Handshake bundle between the iteration controller and its environment.
// master: the requester / counter side; slave: the controller itself.
interface iter_ctrl_if;
  logic start;
  logic ack;
  logic cnt_cout;
  logic ready;
  logic load_en;
  logic cnt_en;
  logic acc_en;
  logic done;
  logic err;

  modport master (
    output start, ack, cnt_cout,
    input  ready, load_en, cnt_en, acc_en, done, err
  );

  modport slave (
    input  start, ack, cnt_cout,
    output ready, load_en, cnt_en, acc_en, done, err
  );
endinterface

// File: rtl/iter_watchdog.sv
// RUN-cycle watchdog for the iteration controller. The module is only
// compiled when ITER_CTRL_TIMEOUT_EN is defined, so a build without the
// watchdog carries no unused module.
// expired is high in the RUN cycle in which the count reaches TIMEOUT on
// the following edge, so the controller leaves RUN after exactly TIMEOUT
// RUN cycles.
`ifdef ITER_CTRL_TIMEOUT_EN
module iter_watchdog
  import iter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CNT_W = wd_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clr, advance while enabled, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == LAST);

endmodule
`endif

// File: rtl/iter_ctrl.sv
// Iteration controller: sequences one 14-iteration pass of an external
// mod-14 counter and accumulator (IDLE -> LOAD -> RUN -> DONE).
// Optional feature macro ITER_CTRL_TIMEOUT_EN adds a RUN-cycle watchdog
// that forces DONE and raises a sticky err if cnt_cout never arrives.
// Without the macro err is tied low and RUN waits on cnt_cout forever.
// All outputs are registered alongside the state; no input reaches an
// output combinationally.
module iter_ctrl
  import iter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  iter_ctrl_if.slave  bus
);

  if (TIMEOUT < 32'd1) begin : g_timeout_range
    $error("iter_ctrl: TIMEOUT must be at least 1");
  end

  state_e state_q;
  logic   ready_q;
  logic   load_en_q;
  logic   cnt_en_q;
  logic   acc_en_q;
  logic   done_q;
  logic   run_exit_s;

`ifdef ITER_CTRL_TIMEOUT_EN
  logic err_q;
  logic wd_clr_s;
  logic wd_en_s;
  logic wd_expired_s;

  // Watchdog restarts in LOAD so every pass gets a fresh budget
  assign wd_clr_s = (state_q == ST_LOAD);
  assign wd_en_s  = (state_q == ST_RUN);

  iter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr_s),
    .en      (wd_en_s),
    .expired (wd_expired_s)
  );

  assign run_exit_s = bus.cnt_cout || wd_expired_s;
  assign bus.err    = err_q;
`else
  assign run_exit_s = bus.cnt_cout;
  assign bus.err    = 1'b0;
`endif

  // Control FSM: next state and all outputs are registered together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      load_en_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      acc_en_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef ITER_CTRL_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_en_q <= 1'b0;
          acc_en_q <= 1'b0;
          done_q   <= 1'b0;
          if (bus.start) begin
            state_q   <= ST_LOAD;
            ready_q   <= 1'b0;
            load_en_q <= 1'b1;
          end else begin
            state_q   <= ST_IDLE;
            ready_q   <= 1'b1;
            load_en_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          // Single load strobe, then iterate unconditionally
          state_q   <= ST_RUN;
          ready_q   <= 1'b0;
          load_en_q <= 1'b0;
          cnt_en_q  <= 1'b1;
          acc_en_q  <= 1'b1;
          done_q    <= 1'b0;
        end
        ST_RUN: begin
          ready_q   <= 1'b0;
          load_en_q <= 1'b0;
          if (run_exit_s) begin
            // Counter wraps 13->0 on this same edge
            state_q  <= ST_DONE;
            cnt_en_q <= 1'b0;
            acc_en_q <= 1'b0;
            done_q   <= 1'b1;
`ifdef ITER_CTRL_TIMEOUT_EN
            if (wd_expired_s && !bus.cnt_cout) begin
              err_q <= 1'b1;
            end else begin
              err_q <= err_q;
            end
`endif
          end else begin
            state_q  <= ST_RUN;
            cnt_en_q <= 1'b1;
            acc_en_q <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        ST_DONE: begin
          load_en_q <= 1'b0;
          cnt_en_q  <= 1'b0;
          acc_en_q  <= 1'b0;
          // start is deliberately ignored here, even alongside ack
          if (bus.ack) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= ST_DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          ready_q   <= 1'b1;
          load_en_q <= 1'b0;
          cnt_en_q  <= 1'b0;
          acc_en_q  <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.load_en = load_en_q;
  assign bus.cnt_en  = cnt_en_q;
  assign bus.acc_en  = acc_en_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_iter_ctrl.sv
// Scoreboard bench for iter_ctrl with an attached mod-14 counter model.
// Each accepted start pushes the expected pass result; a monitor pops and
// compares when done rises.
module tb_iter_ctrl;
  import iter_pkg::*;

  localparam int TO = 16;

  typedef struct {
    int start_cyc;
    int iters;
    bit err;
    bit chk_cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic [3:0] cnt_m;
  logic force_zero;
  int   cyc;
  int   checks;
  int   errors;
  int   load_cnt;
  int   loads_exp;
  bit   err_model;
  exp_t expq[$];

  iter_ctrl_if bus();

  iter_ctrl #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external mod-14 counter sharing the reset
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_m <= 4'd0;
    else if (bus.cnt_en) cnt_m <= (cnt_m == 4'd13) ? 4'd0 : cnt_m + 4'd1;
  end
  assign bus.cnt_cout = !force_zero && (cnt_m == 4'd13);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.ready, bus.load_en, bus.cnt_en, bus.acc_en, bus.done, bus.err};
  endfunction

  // monitor: counts enables per pass and scores each rising done
  initial begin : monitor
    int   acc_cnt;
    int   cen_cnt;
    logic done_prev;
    exp_t e;
    acc_cnt = 0; cen_cnt = 0; done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        acc_cnt = 0; cen_cnt = 0; done_prev = 1'b0;
      end else begin
        if (bus.load_en) begin acc_cnt = 0; cen_cnt = 0; load_cnt++; end
        if (bus.acc_en) acc_cnt++;
        if (bus.cnt_en) cen_cnt++;
        if (bus.done && !done_prev) begin
          if (expq.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = expq.pop_front();
            check("acc_en_cycles", acc_cnt, e.iters);
            check("cnt_en_cycles", cen_cnt, e.iters);
            check("start_to_done", cyc - e.start_cyc, e.iters + 2);
            check("err_at_done", {31'd0, bus.err}, {31'd0, e.err});
            if (e.chk_cnt) check("counter_wrapped", {28'd0, cnt_m}, 32'd0);
          end
        end
        done_prev = bus.done;
      end
    end
  end

  // one pass: start now (bench is idle), wait done, hold, ack
  task automatic run_pass(input int ack_dly, input bit noise, input bit both);
    exp_t e;
    check("ready_idle", {31'd0, bus.ready}, 32'd1);
    if (force_zero) err_model = 1'b1;
    e.start_cyc = cyc;
    e.iters     = force_zero ? TO : ITER_COUNT;
    e.err       = err_model;
    e.chk_cnt   = !force_zero;
    expq.push_back(e);
    loads_exp++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("load_strobe", {31'd0, bus.load_en}, 32'd1);
    for (int i = 0; i < 40 && bus.done !== 1'b1; i++) begin
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("done_reached", {31'd0, bus.done}, 32'd1);
    for (int i = 0; i < ack_dly; i++) begin
      check("done_hold", {29'd0, bus.done, bus.cnt_en, bus.acc_en}, 32'd4);
      if (noise) bus.start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.ack   = 1'b1;
    bus.start = both;
    @(negedge clk);
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check("ready_after_ack", {30'd0, bus.ready, bus.done}, 32'd2);
    check("err_after_ack", {31'd0, bus.err}, {31'd0, err_model});
  endtask

  initial begin : stim
    checks = 0; errors = 0; load_cnt = 0; loads_exp = 0;
    err_model = 1'b0; force_zero = 1'b0; cyc = 0;
    rst = 1'b0; bus.start = 1'b0; bus.ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_values", outs(), 32'h20);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", outs(), 32'h20);
    check("counter_reset", {28'd0, cnt_m}, 32'd0);

    // basic pass with ack withheld for 10 cycles
    run_pass(10, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    // start noise in LOAD/RUN/DONE and start alongside ack
    run_pass(3, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    check("no_extra_pass", load_cnt, loads_exp);
    // back-to-back: start in the cycle after ack
    run_pass(0, 1'b0, 1'b0);
    run_pass(0, 1'b0, 1'b0);

    // reset during RUN iteration 7
    loads_exp++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check("run_iter7_active", {31'd0, bus.acc_en}, 32'd1);
    #2 rst = 1'b0;
    #1 check("async_reset_values", outs(), 32'h20);
    check("async_reset_counter", {28'd0, cnt_m}, 32'd0);
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_pass(1, 1'b0, 1'b0);

    // randomized passes with idle gaps and stray acks
    for (int p = 0; p < 6; p++) begin
      run_pass($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        bus.ack = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.ack = 1'b0;
    end

`ifdef ITER_CTRL_TIMEOUT_EN
    // watchdog: counter carry never arrives
    force_zero = 1'b1;
    run_pass(2, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("err_sticky_idle", {31'd0, bus.err}, 32'd1);
    rst = 1'b0;
    #1 check("err_cleared_by_reset", outs(), 32'h20);
    force_zero = 1'b0;
    err_model  = 1'b0;
    expq.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_pass(0, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("load_pulse_total", load_cnt, loads_exp);
    check("scoreboard_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : time_limit
    #400000;
    $display("FAIL time_limit actual=%0d expected=below %0d cycles", cyc, 40000);
    $fatal(1, "simulation time limit reached");
  end

endmodule
